// File: rtl/mc_main_control_pkg.sv
// Shared constants and types for the multicycle MIPS-subset main control FSM.
package mc_main_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] aluop;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Combinational strobe decoder: maps the current state (plus mem_ready/opcode) to datapath controls.
module mc_control_decode
    import mc_main_control_pkg::*;
(
    input  logic       hold,
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        // hold forces every strobe low while the FSM is being reset
        if (!hold) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.aluop     = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b  = SRCB_IMM_SH;
                    ctrl.aluop      = ALUOP_ADD;
                    ctrl.illegal_op = !op_legal(opcode);
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.aluop     = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.iord       = 1'b1;
                    ctrl.instr_done = mem_ready;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.aluop     = ALUOP_RTYPE;
                end
                S_ALUWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.aluop         = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                    ctrl.instr_done    = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PCSRC_JUMP;
                    ctrl.instr_done = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS-subset main control: state register, next-state logic and retired-instruction counter.
module mc_main_control
    import mc_main_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [1:0]       aluop,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [CNT_W-1:0] retired_q;
    ctrl_t            ctrl;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ctrl.instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    mc_control_decode u_decode (
        .hold      (reset),
        .state     (state_q),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign aluop         = ctrl.aluop;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;
    assign retired       = retired_q;
    assign state         = state_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: walks lw, sw with waits, R-type, beq, fetch waits, illegal op, reset abort and j.
module tb_mc_main_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_source;
    logic [1:0]  aluop;
    logic        instr_done;
    logic        illegal_op;
    logic [31:0] retired;
    logic [3:0]  state;

    int n_cmp = 0;
    int n_err = 0;
    int ir_pulses;

    mc_main_control #(.CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .aluop         (aluop),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .retired       (retired),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then applied 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic rdy, input logic [5:0] op);
        mem_ready = rdy;
        opcode    = op;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        tick();
        tick();
        drive(1'b1, 6'b100011);
        chk("rst_state",    {28'd0, state}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_ir_write", {31'd0, ir_write}, 32'd0);
        chk("rst_retired",  retired, 32'd0);
        reset = 1'b0;
        #1;

        // lw, zero wait states
        chk("lw_c1_state",  {28'd0, state}, 32'd0);
        chk("lw_c1_rd",     {31'd0, mem_read}, 32'd1);
        chk("lw_c1_irw",    {31'd0, ir_write}, 32'd1);
        chk("lw_c1_pcw",    {31'd0, pc_write}, 32'd1);
        chk("lw_c1_srcb",   {30'd0, alu_src_b}, 32'd1);
        chk("lw_c1_aluop",  {30'd0, aluop}, 32'd3);
        tick(); drive(1'b1, 6'b100011);
        chk("lw_c2_state",  {28'd0, state}, 32'd1);
        chk("lw_c2_srcb",   {30'd0, alu_src_b}, 32'd3);
        chk("lw_c2_aluop",  {30'd0, aluop}, 32'd3);
        tick(); drive(1'b1, 6'b100011);
        chk("lw_c3_state",  {28'd0, state}, 32'd2);
        chk("lw_c3_srca",   {31'd0, alu_src_a}, 32'd1);
        chk("lw_c3_srcb",   {30'd0, alu_src_b}, 32'd2);
        chk("lw_c3_aluop",  {30'd0, aluop}, 32'd3);
        tick(); drive(1'b1, 6'b111111);
        chk("lw_c4_state",  {28'd0, state}, 32'd3);
        chk("lw_c4_iord",   {31'd0, iord}, 32'd1);
        chk("lw_c4_rd",     {31'd0, mem_read}, 32'd1);
        tick(); drive(1'b1, 6'b111111);
        chk("lw_c5_state",  {28'd0, state}, 32'd4);
        chk("lw_c5_regw",   {31'd0, reg_write}, 32'd1);
        chk("lw_c5_m2r",    {31'd0, mem_to_reg}, 32'd1);
        chk("lw_c5_done",   {31'd0, instr_done}, 32'd1);
        chk("lw_c5_ret",    retired, 32'd0);
        tick(); drive(1'b1, 6'b101011);
        chk("lw_ret",       retired, 32'd1);

        // sw with two wait cycles in MEMWR
        chk("sw_c1_state",  {28'd0, state}, 32'd0);
        tick(); drive(1'b1, 6'b101011);
        chk("sw_c2_state",  {28'd0, state}, 32'd1);
        tick(); drive(1'b1, 6'b101011);
        chk("sw_c3_state",  {28'd0, state}, 32'd2);
        tick(); drive(1'b0, 6'b101011);
        chk("sw_c4_state",  {28'd0, state}, 32'd5);
        chk("sw_c4_wr",     {31'd0, mem_write}, 32'd1);
        chk("sw_c4_iord",   {31'd0, iord}, 32'd1);
        chk("sw_c4_done",   {31'd0, instr_done}, 32'd0);
        tick(); drive(1'b0, 6'b101011);
        chk("sw_c5_wr",     {31'd0, mem_write}, 32'd1);
        chk("sw_c5_done",   {31'd0, instr_done}, 32'd0);
        tick(); drive(1'b1, 6'b101011);
        chk("sw_c6_state",  {28'd0, state}, 32'd5);
        chk("sw_c6_wr",     {31'd0, mem_write}, 32'd1);
        chk("sw_c6_regw",   {31'd0, reg_write}, 32'd0);
        chk("sw_c6_rd",     {31'd0, mem_read}, 32'd0);
        chk("sw_c6_done",   {31'd0, instr_done}, 32'd1);
        tick(); drive(1'b1, 6'b000000);
        chk("sw_ret",       retired, 32'd2);

        // R-type then beq, 7 cycles total
        chk("rt_c1_state",  {28'd0, state}, 32'd0);
        tick(); drive(1'b1, 6'b000000);
        chk("rt_c2_state",  {28'd0, state}, 32'd1);
        tick(); drive(1'b1, 6'b000000);
        chk("rt_c3_state",  {28'd0, state}, 32'd6);
        chk("rt_c3_aluop",  {30'd0, aluop}, 32'd0);
        chk("rt_c3_srca",   {31'd0, alu_src_a}, 32'd1);
        chk("rt_c3_srcb",   {30'd0, alu_src_b}, 32'd0);
        tick(); drive(1'b1, 6'b000100);
        chk("rt_c4_state",  {28'd0, state}, 32'd7);
        chk("rt_c4_regdst", {31'd0, reg_dst}, 32'd1);
        chk("rt_c4_regw",   {31'd0, reg_write}, 32'd1);
        chk("rt_c4_m2r",    {31'd0, mem_to_reg}, 32'd0);
        tick(); drive(1'b1, 6'b000100);
        tick(); drive(1'b1, 6'b000100);
        chk("beq_c2_state", {28'd0, state}, 32'd1);
        tick(); drive(1'b1, 6'b001000);
        chk("beq_c3_state", {28'd0, state}, 32'd8);
        chk("beq_c3_aluop", {30'd0, aluop}, 32'd1);
        chk("beq_c3_pwc",   {31'd0, pc_write_cond}, 32'd1);
        chk("beq_c3_psrc",  {30'd0, pc_source}, 32'd1);
        chk("beq_c3_done",  {31'd0, instr_done}, 32'd1);
        tick(); drive(1'b0, 6'b001000);
        chk("beq_ret",      retired, 32'd4);

        // FETCH waits 3 cycles, then an illegal opcode
        ir_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            chk("fw_state", {28'd0, state}, 32'd0);
            chk("fw_irw",   {31'd0, ir_write}, 32'd0);
            chk("fw_pcw",   {31'd0, pc_write}, 32'd0);
            if (ir_write === 1'b1) ir_pulses++;
            tick(); drive(1'b0, 6'b001000);
        end
        drive(1'b1, 6'b001000);
        chk("fw_irw_rdy",   {31'd0, ir_write}, 32'd1);
        if (ir_write === 1'b1) ir_pulses++;
        tick(); drive(1'b1, 6'b001000);
        if (ir_write === 1'b1) ir_pulses++;
        chk("fw_ir_pulses", ir_pulses, 32'd1);
        chk("ill_state",    {28'd0, state}, 32'd1);
        chk("ill_pulse",    {31'd0, illegal_op}, 32'd1);
        chk("ill_regw",     {31'd0, reg_write}, 32'd0);
        chk("ill_memw",     {31'd0, mem_write}, 32'd0);
        chk("ill_done",     {31'd0, instr_done}, 32'd0);
        tick(); drive(1'b1, 6'b100011);
        chk("ill_next",     {28'd0, state}, 32'd0);
        chk("ill_nopulse",  {31'd0, illegal_op}, 32'd0);
        chk("ill_ret",      retired, 32'd4);

        // lw aborted by reset while waiting in MEMRD
        tick(); drive(1'b1, 6'b100011);
        tick(); drive(1'b0, 6'b100011);
        tick(); drive(1'b0, 6'b100011);
        chk("ab_state",     {28'd0, state}, 32'd3);
        reset = 1'b1;
        drive(1'b1, 6'b100011);
        chk("ab_rst_rd",    {31'd0, mem_read}, 32'd0);
        chk("ab_rst_done",  {31'd0, instr_done}, 32'd0);
        tick(); drive(1'b1, 6'b000010);
        reset = 1'b0;
        #1;
        chk("ab_next",      {28'd0, state}, 32'd0);
        chk("ab_ret",       retired, 32'd0);
        chk("ab_regw",      {31'd0, reg_write}, 32'd0);

        // j afterwards
        tick(); drive(1'b1, 6'b000010);
        chk("j_c2_state",   {28'd0, state}, 32'd1);
        tick(); drive(1'b1, 6'b000000);
        chk("j_c3_state",   {28'd0, state}, 32'd9);
        chk("j_c3_pcw",     {31'd0, pc_write}, 32'd1);
        chk("j_c3_psrc",    {30'd0, pc_source}, 32'd2);
        chk("j_c3_done",    {31'd0, instr_done}, 32'd1);
        tick(); drive(1'b0, 6'b000000);
        chk("j_next",       {28'd0, state}, 32'd0);
        chk("j_ret",        retired, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
Multicycle MIPS-subset main control FSM. Sits directly upstream of the ALU control decoder and drives its 2-bit aluop, plus every datapath strobe: PC, IR, memory, register file and mux selects. Sequences each instruction through fetch, decode, execute, memory and writeback. Waits on a memory-ready handshake during memory states.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; state->FETCH, counter->0
opcode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
iord  out  1  0=PC, 1=ALUOut as memory address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  1=MDR, 0=ALUOut to register write data
reg_dst  out  1  1=rd, 0=rt
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
aluop  out  2  to ALU control: 00=R-type (funct), 01=sub (beq), 11=add
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
retired  out  CNT_W  count of instr_done pulses, wraps modulo 2^CNT_W
state  out  4  current state encoding, for debug

Behaviour:
- Moore FSM with a registered state. Outputs decode from state; FETCH, MEMRD and MEMWR additionally gate their strobes with mem_ready as stated below.
- Any output not listed for a state is 0. During reset, every strobe and pulse is 0 and retired=0.
- FETCH (0):
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=11, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE on mem_ready.
- DECODE (1):
  - Drives alu_src_a=0, alu_src_b=11, aluop=11.
  - Next state by opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - any other -> FETCH with illegal_op=1; no instr_done, retired unchanged.
- MEMADR (2): alu_src_a=1, alu_src_b=10, aluop=11. lw -> MEMRD, sw -> MEMWR.
- MEMRD (3): mem_read=1, iord=1. Waits for mem_ready, then -> MEMWB.
- MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEMWR (5): mem_write=1, iord=1. Waits for mem_ready; on ready, instr_done=1 and -> FETCH.
- EXEC (6): alu_src_a=1, alu_src_b=00, aluop=00 -> ALUWB.
- ALUWB (7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
- JUMP (9): pc_write=1, pc_source=10, instr_done=1 -> FETCH.
- Minimum cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, beq 3, j 3. Each cycle that mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle.
- mem_write and reg_write are never both high; mem_read and mem_write are never both high.
- Unused encodings 10-15 -> FETCH on the next clock, all outputs 0.
- Reset mid-instruction, including during a memory wait, aborts the instruction: FETCH on the next edge, no instr_done, retired=0.
- opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.
- mem_ready high outside FETCH/MEMRD/MEMWR is ignored.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J)
  - aluop constants (ALUOP_RTYPE=00, ALUOP_SUB=01, ALUOP_ADD=11)
  - state encodings
  - alu_src_b and pc_source encodings
- One natural sub-module, mc_control_decode: combinational state+mem_ready -> strobe decoder. The parent keeps the state register, next-state logic and retired counter.

Test Plan:
- lw (opcode 100011), mem_ready always 1 -> states 0,1,2,3,4; reg_write and mem_to_reg high in cycle 5; aluop 11,11,11; retired 0->1.
- sw with mem_ready low for 2 cycles in MEMWR -> mem_write high for 3 cycles, iord=1, instr_done on the third, total 6 cycles.
- R-type then beq -> aluop=00 in EXEC; beq: aluop=01, pc_write_cond=1, pc_source=01; retired=2 after 7 cycles.
- FETCH with mem_ready low for 3 cycles -> ir_write/pc_write stay 0 until ready; exactly one ir_write pulse.
- opcode 001000 in DECODE -> illegal_op pulse, next state FETCH, retired unchanged, no register/memory strobe.
- reset asserted in MEMRD -> FETCH next cycle, retired=0, no reg_write; j instruction afterwards -> pc_write=1 with pc_source=10 in cycle 3.
